// File: rtl/fetch_refill_axi.sv
// ============================================================================
// Module   : fetch_refill_axi
// Function : I-fetch miss engine: uncached single reads and wrapping line
//            refills over AXI, with rresp/rlast checking and snoop masking.
//            Optional critical-word forwarding when FETCH_REFILL_CWF_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_refill_axi #(
  parameter int         LINE_WORDS  = 16,
  parameter logic [3:0] AXI_ID      = 4'd0,
  parameter int         SNOOP_IDX_W = 7,
  parameter int         PD_W        = 36
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   pc,
  input  logic                          cctrl_miss,
  input  logic                          cctrl_uncached,
  input  logic                          snoop_hit,
  input  logic [31:0]                   snoop_addr,
  output logic [31:0]                   snoop_query_addr,
  input  logic                          snoop_query_hit,
  output logic [31:0]                   predecode_dout,
  input  logic [PD_W-1:0]               predecode_din,
  output logic                          update_data_wea,
  output logic [31:0]                   update_data_addr,
  output logic [PD_W-1:0]               update_data_din,
  output logic                          update_tag_wea,
  output logic [32:0]                   update_tag,
  output logic                          buffer_uncached_we,
  output logic [31:0]                   buffer_uncached_addr,
  output logic [PD_W-1:0]               buffer_uncached_din,
  output logic                          buffer_refilled_we,
  output logic [$clog2(LINE_WORDS)-1:0] buffer_refilled_addr,
  output logic [PD_W-1:0]               buffer_refilled_din,
  output logic                          buffer_refilled_reset,
  output logic                          fetch_cwf_valid,
  output logic [PD_W-1:0]               fetch_cwf_din,
  output logic                          fetch_err,
  output logic [3:0]                    axi_m_arid,
  output logic [31:0]                   axi_m_araddr,
  output logic [7:0]                    axi_m_arlen,
  output logic [2:0]                    axi_m_arsize,
  output logic [1:0]                    axi_m_arburst,
  output logic                          axi_m_aruser,
  output logic                          axi_m_arvalid,
  input  logic                          axi_m_arready,
  input  logic [3:0]                    axi_m_rid,
  input  logic [31:0]                   axi_m_rdata,
  input  logic [1:0]                    axi_m_rresp,
  input  logic                          axi_m_rlast,
  input  logic                          axi_m_rvalid,
  output logic                          axi_m_rready
);

  localparam int              WP_W = $clog2(LINE_WORDS);
  localparam int              OFS  = WP_W + 2;
  localparam int              SHI  = OFS + SNOOP_IDX_W - 1;
  localparam logic [WP_W-1:0] LAST = WP_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UNC_ADDR = 3'd1,
    S_UNC_DATA = 3'd2,
    S_REF_ADDR = 3'd3,
    S_REF_DATA = 3'd4,
    S_COMMIT   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_curaddr;
  logic [WP_W-1:0] r_wptr;
  logic [WP_W-1:0] r_cnt;
  logic            r_err;
  logic            r_snoop_hit;
  logic [31:0]     r_araddr;
  logic [7:0]      r_arlen;
  logic [2:0]      r_arsize;
  logic [1:0]      r_arburst;
  logic            r_aruser;
  logic            r_arvalid;

  logic            w_beat;
  logic            w_rlast_bad;
  logic            w_snoop_match;
  logic            w_unused;

  assign w_beat        = axi_m_rvalid && (axi_m_rid == AXI_ID);
  assign w_rlast_bad   = axi_m_rlast != (r_cnt == LAST);
  assign w_snoop_match = snoop_hit && (r_state != S_IDLE) &&
                         (snoop_addr[SHI:OFS] == r_curaddr[SHI:OFS]);

  assign axi_m_arid    = AXI_ID;
  assign axi_m_araddr  = r_araddr;
  assign axi_m_arlen   = r_arlen;
  assign axi_m_arsize  = r_arsize;
  assign axi_m_arburst = r_arburst;
  assign axi_m_aruser  = r_aruser;
  assign axi_m_arvalid = r_arvalid;
  assign axi_m_rready  = 1'b1;

  assign snoop_query_addr     = r_curaddr;
  assign predecode_dout       = axi_m_rdata;
  assign update_data_addr     = {r_curaddr[31:OFS], r_wptr, 2'b00};
  assign update_data_din      = predecode_din;
  assign buffer_uncached_addr = r_curaddr;
  assign buffer_uncached_din  = predecode_din;
  assign buffer_refilled_addr = r_wptr;
  assign buffer_refilled_din  = predecode_din;

`ifdef FETCH_REFILL_CWF_EN
  assign fetch_cwf_din = predecode_din;
`else
  assign fetch_cwf_din = '0;
`endif

  assign w_unused = &{1'b0, snoop_addr[31:SHI+1], snoop_addr[OFS-1:0], axi_m_rresp[0]};

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next                = r_state;
    update_data_wea       = 1'b0;
    update_tag_wea        = 1'b0;
    update_tag            = {1'b0, r_curaddr};
    buffer_uncached_we    = 1'b0;
    buffer_refilled_we    = 1'b0;
    buffer_refilled_reset = 1'b0;
    fetch_cwf_valid       = 1'b0;
    fetch_err             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cctrl_uncached)  w_next = S_UNC_ADDR;
        else if (cctrl_miss) w_next = S_REF_ADDR;
      end
      // A snoop-filter hit cancels the request before the handshake counts.
      S_UNC_ADDR, S_REF_ADDR: begin
        if (snoop_query_hit)    w_next = S_IDLE;
        else if (axi_m_arready) w_next = (r_state == S_UNC_ADDR) ? S_UNC_DATA : S_REF_DATA;
      end
      S_UNC_DATA: begin
        if (w_beat) begin
          if (axi_m_rresp[1]) fetch_err          = 1'b1;
          else                buffer_uncached_we = !r_snoop_hit;
          w_next = S_IDLE;
        end
      end
      S_REF_DATA: begin
        if (w_beat) begin
          update_data_wea    = !r_snoop_hit;
          buffer_refilled_we = !r_snoop_hit;
          update_tag_wea     = !r_snoop_hit;
`ifdef FETCH_REFILL_CWF_EN
          fetch_cwf_valid    = (r_cnt == '0) && !r_snoop_hit && !r_err && !axi_m_rresp[1];
`endif
          if (r_cnt == LAST) w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        buffer_refilled_reset = 1'b1;
        if (r_err) begin
          fetch_err = 1'b1;
        end else if (!r_snoop_hit) begin
          update_tag_wea = 1'b1;
          update_tag     = {1'b1, r_curaddr};
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_curaddr   <= '0;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_snoop_hit <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_aruser    <= 1'b0;
      r_arvalid   <= 1'b0;
    end else begin
      if (w_next == S_IDLE)  r_snoop_hit <= 1'b0;
      else if (w_snoop_match) r_snoop_hit <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cctrl_uncached) begin
            r_curaddr <= pc;
            r_araddr  <= pc;
            r_arlen   <= 8'd0;
            r_arsize  <= 3'b010;
            r_arburst <= 2'b01;
            r_aruser  <= 1'b1;
            r_arvalid <= 1'b1;
          end else if (cctrl_miss) begin
            r_curaddr <= pc;
            r_wptr    <= pc[OFS-1:2];
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_araddr  <= pc;
            r_arlen   <= 8'(LINE_WORDS - 1);
            r_arsize  <= 3'b010;
            r_arburst <= 2'b10;
            r_aruser  <= 1'b0;
            r_arvalid <= 1'b1;
          end
        end
        S_UNC_ADDR, S_REF_ADDR: begin
          if (snoop_query_hit || axi_m_arready) r_arvalid <= 1'b0;
        end
        S_REF_DATA: begin
          if (w_beat) begin
            r_wptr <= r_wptr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (axi_m_rresp[1] || w_rlast_bad) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_refill_axi.sv
// ============================================================================
// Module   : tb_fetch_refill_axi
// Function : Scoreboard bench for fetch_refill_axi (LINE_WORDS=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_refill_axi;

  localparam logic [3:0] ID = 4'd0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc = '0;
  logic        cctrl_miss = 1'b0, cctrl_uncached = 1'b0;
  logic        snoop_hit = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic [31:0] snoop_query_addr;
  logic        snoop_query_hit = 1'b0;
  logic [31:0] predecode_dout;
  logic [35:0] predecode_din;
  logic        update_data_wea;
  logic [31:0] update_data_addr;
  logic [35:0] update_data_din;
  logic        update_tag_wea;
  logic [32:0] update_tag;
  logic        buffer_uncached_we;
  logic [31:0] buffer_uncached_addr;
  logic [35:0] buffer_uncached_din;
  logic        buffer_refilled_we;
  logic [3:0]  buffer_refilled_addr;
  logic [35:0] buffer_refilled_din;
  logic        buffer_refilled_reset;
  logic        fetch_cwf_valid;
  logic [35:0] fetch_cwf_din;
  logic        fetch_err;
  logic [3:0]  axi_m_arid;
  logic [31:0] axi_m_araddr;
  logic [7:0]  axi_m_arlen;
  logic [2:0]  axi_m_arsize;
  logic [1:0]  axi_m_arburst;
  logic        axi_m_aruser, axi_m_arvalid;
  logic        axi_m_arready = 1'b0;
  logic [3:0]  axi_m_rid = '0;
  logic [31:0] axi_m_rdata = '0;
  logic [1:0]  axi_m_rresp = '0;
  logic        axi_m_rlast = 1'b0, axi_m_rvalid = 1'b0;
  logic        axi_m_rready;

  // Predecoder model: tag the returned word with a fixed nibble.
  assign predecode_din = {4'hA, predecode_dout};

  always #5 clk = ~clk;

  fetch_refill_axi dut (
    .clk(clk), .resetn(resetn), .pc(pc),
    .cctrl_miss(cctrl_miss), .cctrl_uncached(cctrl_uncached),
    .snoop_hit(snoop_hit), .snoop_addr(snoop_addr),
    .snoop_query_addr(snoop_query_addr), .snoop_query_hit(snoop_query_hit),
    .predecode_dout(predecode_dout), .predecode_din(predecode_din),
    .update_data_wea(update_data_wea), .update_data_addr(update_data_addr),
    .update_data_din(update_data_din), .update_tag_wea(update_tag_wea),
    .update_tag(update_tag), .buffer_uncached_we(buffer_uncached_we),
    .buffer_uncached_addr(buffer_uncached_addr), .buffer_uncached_din(buffer_uncached_din),
    .buffer_refilled_we(buffer_refilled_we), .buffer_refilled_addr(buffer_refilled_addr),
    .buffer_refilled_din(buffer_refilled_din), .buffer_refilled_reset(buffer_refilled_reset),
    .fetch_cwf_valid(fetch_cwf_valid), .fetch_cwf_din(fetch_cwf_din),
    .fetch_err(fetch_err),
    .axi_m_arid(axi_m_arid), .axi_m_araddr(axi_m_araddr), .axi_m_arlen(axi_m_arlen),
    .axi_m_arsize(axi_m_arsize), .axi_m_arburst(axi_m_arburst), .axi_m_aruser(axi_m_aruser),
    .axi_m_arvalid(axi_m_arvalid), .axi_m_arready(axi_m_arready),
    .axi_m_rid(axi_m_rid), .axi_m_rdata(axi_m_rdata), .axi_m_rresp(axi_m_rresp),
    .axi_m_rlast(axi_m_rlast), .axi_m_rvalid(axi_m_rvalid), .axi_m_rready(axi_m_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [49:0] q_ar[$];   // {id, addr, len, size, burst, user}
  logic [67:0] q_dw[$];   // {addr, din}
  logic [39:0] q_rb[$];   // {addr, din}
  logic [32:0] q_tag[$];
  logic [67:0] q_unc[$];
  int          q_err[$];
  logic [35:0] q_cwf[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [67:0] e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (axi_m_arvalid && axi_m_arready) begin
          if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else chk("ar", 64'({axi_m_arid, axi_m_araddr, axi_m_arlen, axi_m_arsize,
                              axi_m_arburst, axi_m_aruser}), 64'(q_ar.pop_front()));
        end
        if (update_data_wea) begin
          if (q_dw.size() == 0) chk("data_we_unexpected", 1, 0);
          else begin
            e = q_dw.pop_front();
            chk("data_addr", 64'(update_data_addr), 64'(e[67:36]));
            chk("data_din", 64'(update_data_din), 64'(e[35:0]));
          end
        end
        if (buffer_refilled_we) begin
          if (q_rb.size() == 0) chk("rbuf_we_unexpected", 1, 0);
          else chk("rbuf", 64'({buffer_refilled_addr, buffer_refilled_din}), 64'(q_rb.pop_front()));
        end
        if (update_tag_wea) begin
          if (q_tag.size() == 0) chk("tag_we_unexpected", 1, 0);
          else chk("tag", 64'(update_tag), 64'(q_tag.pop_front()));
        end
        if (buffer_uncached_we) begin
          if (q_unc.size() == 0) chk("unc_we_unexpected", 1, 0);
          else begin
            e = q_unc.pop_front();
            chk("unc_addr", 64'(buffer_uncached_addr), 64'(e[67:36]));
            chk("unc_din", 64'(buffer_uncached_din), 64'(e[35:0]));
          end
        end
        if (fetch_err) begin
          if (q_err.size() == 0) chk("err_unexpected", 1, 0);
          else chk("err_pulse", 1, 64'(q_err.pop_front()));
        end
        if (fetch_cwf_valid) begin
          if (q_cwf.size() == 0) chk("cwf_unexpected", 1, 0);
          else chk("cwf_din", 64'(fetch_cwf_din), 64'(q_cwf.pop_front()));
        end
      end
    end
  endtask

  // One line refill; beat indices are 0-based, -1 disables the option.
  task automatic refill(input logic [31:0] a, input int err_beat, input int snoop_beat,
                        input int foreign_at, input bit drop_rlast);
    logic [3:0] w;
    bit err, snp;
    err = 0; snp = 0;
    w = a[5:2];
    cctrl_miss = 1'b1; pc = a;
    q_ar.push_back({ID, a, 8'd15, 3'b010, 2'b10, 1'b0});
    tick();
    cctrl_miss = 1'b0;
    chk("ref_arvalid_rise", 64'(axi_m_arvalid), 1);
    axi_m_arready = 1'b1;
    tick();
    axi_m_arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == foreign_at) begin
        axi_m_rvalid = 1'b1; axi_m_rid = 4'h5; axi_m_rdata = 32'hBAD0_BAD0;
        axi_m_rresp = 2'b00; axi_m_rlast = 1'b0;
        tick();
      end
      axi_m_rvalid = 1'b1; axi_m_rid = ID;
      axi_m_rdata  = 32'hD000_0000 + 32'(i * 17);
      axi_m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      axi_m_rlast  = drop_rlast ? 1'b0 : (i == 15);
      snoop_hit    = (i == snoop_beat); snoop_addr = a;
      if (!snp) begin
        q_dw.push_back({a[31:6], w, 2'b00, 4'hA, axi_m_rdata});
        q_rb.push_back({w, 4'hA, axi_m_rdata});
        q_tag.push_back({1'b0, a});
      end
`ifdef FETCH_REFILL_CWF_EN
      if (i == 0 && axi_m_rresp == 2'b00) q_cwf.push_back({4'hA, axi_m_rdata});
`endif
      if (axi_m_rresp[1] || (axi_m_rlast != (i == 15))) err = 1;
      if (i == snoop_beat) snp = 1;
      w = w + 4'd1;
      tick();
    end
    axi_m_rvalid = 1'b0; axi_m_rlast = 1'b0; axi_m_rresp = 2'b00; snoop_hit = 1'b0;
    if (err) q_err.push_back(1);
    else if (!snp) q_tag.push_back({1'b1, a});
    tick();
  endtask

  task automatic uncached(input logic [31:0] a, input logic [1:0] resp);
    cctrl_uncached = 1'b1; pc = a;
    q_ar.push_back({ID, a, 8'd0, 3'b010, 2'b01, 1'b1});
    tick();
    cctrl_uncached = 1'b0;
    chk("unc_arvalid_rise", 64'(axi_m_arvalid), 1);
    axi_m_arready = 1'b1;
    tick();
    axi_m_arready = 1'b0;
    tick();
    axi_m_rvalid = 1'b1; axi_m_rid = ID; axi_m_rdata = a ^ 32'h0F0F_1234;
    axi_m_rresp = resp; axi_m_rlast = 1'b1;
    if (resp[1]) q_err.push_back(1);
    else q_unc.push_back({a, 4'hA, axi_m_rdata});
    tick();
    axi_m_rvalid = 1'b0; axi_m_rlast = 1'b0; axi_m_rresp = 2'b00;
  endtask

  task automatic stimulus();
    repeat (3) tick();
    chk("rst_arvalid", 64'(axi_m_arvalid), 0);
    chk("rst_araddr", 64'(axi_m_araddr), 0);
    chk("rst_arlen", 64'(axi_m_arlen), 0);
    chk("rst_rready", 64'(axi_m_rready), 1);
    chk("rst_strobes", 64'({update_data_wea, update_tag_wea, buffer_uncached_we,
                            buffer_refilled_we, fetch_err, fetch_cwf_valid}), 0);
    resetn = 1'b1;
    tick();
    refill(32'h1000_0038, -1, -1, 3, 1'b0);
    uncached(32'h1FC0_0000, 2'b00);
    uncached(32'h1FC0_0010, 2'b10);
    refill(32'h2000_0040, 4, -1, -1, 1'b0);
    refill(32'h3000_1104, -1, 2, -1, 1'b0);
    // Snoop-filter hit while the address phase is stalled.
    cctrl_miss = 1'b1; pc = 32'h4000_0000;
    tick();
    cctrl_miss = 1'b0;
    chk("sq_arvalid_rise", 64'(axi_m_arvalid), 1);
    tick();
    chk("sq_arvalid_hold", 64'({axi_m_arvalid, axi_m_araddr}), {1'b1, 32'h4000_0000});
    chk("sq_query_addr", 64'(snoop_query_addr), 64'h4000_0000);
    snoop_query_hit = 1'b1;
    tick();
    snoop_query_hit = 1'b0;
    chk("sq_arvalid_drop", 64'(axi_m_arvalid), 0);
    axi_m_arready = 1'b1;
    tick();
    axi_m_arready = 1'b0;
    refill(32'h5000_0000, -1, -1, -1, 1'b1);
    refill(32'h6000_007C, -1, -1, -1, 1'b0);
    repeat (4) tick();
    chk("left_ar", 64'(q_ar.size()), 0);
    chk("left_data", 64'(q_dw.size()), 0);
    chk("left_rbuf", 64'(q_rb.size()), 0);
    chk("left_tag", 64'(q_tag.size()), 0);
    chk("left_unc", 64'(q_unc.size()), 0);
    chk("left_err", 64'(q_err.size()), 0);
    chk("left_cwf", 64'(q_cwf.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_refill_axi.md
# fetch_refill_axi

Parametrised instruction-fetch miss engine between the I-cache controller and the AXI read port. It issues single-beat uncached reads and wrapping line refills of configurable length. Returned words are written into the data array and refill buffer, and the tag is committed once the burst completes. Unlike the previous fetch-to-AXI controller, it adds a configurable line size, AXI ID, `rlast`/`rresp` checking with a fetch error report, and optional critical-word forwarding.

## Interface
- `LINE_WORDS`, 16: words per cache line; power of two, 4..16. `OFS = log2(LINE_WORDS)+2` is the line-offset width.
- `AXI_ID`, 4'd0: constant driven on `axi_m_arid`; `rid` must match it.
- `SNOOP_IDX_W`, 7: snoop compare bits `[OFS+SNOOP_IDX_W-1:OFS]`.
- `PD_W`, 36: width of a predecoded word.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `pc` in 32: fetch address.
- `cctrl_miss` in 1: cacheable miss request.
- `cctrl_uncached` in 1: uncached fetch request; wins over `cctrl_miss`.
- `snoop_hit` in 1, `snoop_addr` in 32: invalidation snoop.
- `snoop_query_addr` out 32, `snoop_query_hit` in 1: snoop-filter lookup, driven with `curaddr`.
- `predecode_dout` out 32, `predecode_din` in PD_W: `rdata` to the predecoder and back.
- `update_data_wea` out 1, `update_data_addr` out 32, `update_data_din` out PD_W: data-array write.
- `update_tag_wea` out 1, `update_tag` out 33: tag write, formatted `{valid, curaddr}`.
- `buffer_uncached_we` out 1, `buffer_uncached_addr` out 32, `buffer_uncached_din` out PD_W.
- `buffer_refilled_we` out 1, `buffer_refilled_addr` out log2(LINE_WORDS), `buffer_refilled_din` out PD_W, `buffer_refilled_reset` out 1.
- `fetch_cwf_valid` out 1, `fetch_cwf_din` out PD_W: critical word, valid only when `FETCH_REFILL_CWF_EN` is defined.
- `fetch_err` out 1: one-cycle pulse on a bus error.
- AXI AR channel: `axi_m_arid` out 4, `axi_m_araddr` out 32, `axi_m_arlen` out 8, `axi_m_arsize` out 3, `axi_m_arburst` out 2, `axi_m_aruser` out 1, `axi_m_arvalid` out 1, `axi_m_arready` in 1.
- AXI R channel: `axi_m_rid` in 4, `axi_m_rdata` in 32, `axi_m_rresp` in 2, `axi_m_rlast` in 1, `axi_m_rvalid` in 1, `axi_m_rready` out 1.

## Operation
- States: IDLE, UNC_ADDR, UNC_DATA, REF_ADDR, REF_DATA, COMMIT.
- **IDLE**
  - `cctrl_uncached`: latch `curaddr = pc`, go to UNC_ADDR. AR = {`pc`, len 0, size 3'b010, INCR, user 1}.
  - Else `cctrl_miss`: latch `curaddr`, set word pointer `wptr = pc[OFS-1:2]`, clear beat counter and error flag, go to REF_ADDR. AR = {`pc`, len `LINE_WORDS-1`, size 3'b010, WRAP, user 0}.
- **UNC_ADDR / REF_ADDR**
  - `snoop_query_hit`: drop `arvalid` and return to IDLE. This check is evaluated before `arready`.
  - `arready`: drop `arvalid` and go to the matching DATA state.
- **UNC_DATA**
  - Accept a beat on `rvalid & rid==AXI_ID`.
  - `rresp[1]==0`: write the uncached buffer.
  - Otherwise: pulse `fetch_err` and suppress the write.
  - Go to IDLE in either case.
- **REF_DATA**, per accepted beat:
  - Write data array at `{curaddr[31:OFS], wptr, 2'b00}`.
  - Write refill buffer at `wptr`.
  - Increment `wptr` modulo `LINE_WORDS` and increment the beat counter.
  - `update_tag_wea` pulses with valid=0 to invalidate the line during the fill.
  - Error flag sets on `rresp[1]`.
  - Error flag also sets if `rlast` is wrong: asserted before beat `LINE_WORDS`, or absent on it.
  - Leave on the beat with counter `== LINE_WORDS-1` → COMMIT. The master does not wait for an `rlast` that never arrives.
- **COMMIT**: one cycle, then IDLE.
  - No error and no snoop: `update_tag_wea=1`, `update_tag={1,curaddr}`, `buffer_refilled_reset=1`.
  - Error: no valid tag, `fetch_err` pulses, `buffer_refilled_reset=1`.
- **Snoop**
  - `snoop_hit_R` sets when `snoop_hit` and the snoop index bits of `snoop_addr` equal those of `curaddr` while not in IDLE.
  - It clears on entering IDLE.
  - While set, all array, buffer and tag writes are masked. The burst still drains.
- `axi_m_rready` is constant 1. Beats with a foreign `rid` are ignored.

## Timing
- Reset values: all AR outputs 0, `arvalid` 0, state IDLE, all write enables and pulses 0, `rready` 1.
- AR outputs are registered: `arvalid` rises the cycle after the request is seen in IDLE, and holds stable until `arready`.
- All write strobes are combinational in the beat's `rvalid` cycle. The tag commit comes 1 cycle after the last beat.
- Requests arriving while not in IDLE are ignored; the cache controller holds its request.
- Reset mid-burst returns to IDLE immediately. Later R beats are ignored by the next request only through the beat counter, so the system resets AXI together with this block.

## Configuration
- **`FETCH_REFILL_CWF_EN` defined:** `fetch_cwf_valid` pulses with the first refill beat, unless the snoop or error flag masks it or that beat carries an error response. `fetch_cwf_din = predecode_din`. This gives the pipeline an early restart.
- **Not defined:** `fetch_cwf_valid` is tied to 0 and `fetch_cwf_din` to 0. The fetch unit must wait for the tag commit.

## Test plan
- LINE_WORDS=16, miss at `pc=0x1000_0038`: AR len 15, WRAP, arid `AXI_ID`. Data writes at word order 14,15,0..13. Tag `{1,0x1000_0038}` is written 1 cycle after beat 16.
- Uncached at 0x1FC0_0000, `rresp=0`: AR len 0, INCR, user 1. Exactly one `buffer_uncached_we`, state back in IDLE the same cycle.
- Refill with `rresp=2'b10` on beat 5: writes continue, no valid tag, `fetch_err` pulse in COMMIT.
- Snoop with a matching index during beat 3: no further writes, no tag commit, burst drained, IDLE afterwards.
- `snoop_query_hit` during REF_ADDR with `arready` low, then high: `arvalid` drops, no R traffic expected, back in IDLE.
- With `FETCH_REFILL_CWF_EN`, LINE_WORDS=8: `fetch_cwf_valid` asserted exactly once, on beat 1, with that beat's data. Without the macro it stays 0.
